// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer controller.
// Holds the FSM state encoding, word size and default parameters.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } dma_state_e;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_LEN_W      = 16;

endpackage

// File: rtl/dma_fifo_buffer.sv
// Registered staging FIFO between the DMA read and write ports.
// Simultaneous push and pop keep the count unchanged.
module dma_fifo_buffer
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_FIFO_DEPTH,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [AW:0]           count_o,
    output logic                  empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr_q;
    logic [AW-1:0]         rptr_q;
    logic [AW:0]           cnt_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push_i && (cnt_q != FULL_CNT);
    assign do_pop  = pop_i && (cnt_q != '0);
    assign data_o  = mem[rptr_q];
    assign count_o = cnt_q;
    assign empty_o = (cnt_q == '0);

    // Storage array; contents need no reset since pointers gate reads.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q] <= data_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dma_xfer_ctrl.sv
// Memory-to-memory DMA controller with req/gnt/rvalid master ports.
// Reads are throttled so outstanding reads never overflow the FIFO.
module dma_xfer_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned LEN_W      = DEF_LEN_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_req_o,
    output logic [31:0]      rd_addr_o,
    input  logic             rd_gnt_i,
    input  logic             rd_rvalid_i,
    input  logic [31:0]      rd_rdata_i,
    output logic             wr_req_o,
    output logic [31:0]      wr_addr_o,
    output logic [31:0]      wr_wdata_o,
    input  logic             wr_gnt_i,
    input  logic             wr_rvalid_i
);

    localparam int unsigned CW   = LEN_W + 1;
    localparam int unsigned FCW  = $clog2(FIFO_DEPTH) + 1;

    typedef logic [CW-1:0] cnt_t;

    dma_state_e     state_q, state_d;
    logic [31:0]    rd_addr_q, wr_addr_q;
    cnt_t           len_q, rd_iss_q, rd_out_q, wr_cmp_q;
    logic [FCW-1:0] fifo_cnt;
    logic           fifo_empty;
    logic [31:0]    inflight;
    logic           run, launch, rd_fire, wr_fire, push, last_cmp;

    assign run      = (state_q == ST_RUN);
    assign launch   = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign inflight = 32'(rd_out_q) + 32'(fifo_cnt);
    assign rd_req_o = run && (rd_iss_q < len_q) && (inflight < FIFO_DEPTH);
    assign wr_req_o = run && !fifo_empty;
    assign rd_fire  = rd_req_o && rd_gnt_i;
    assign wr_fire  = wr_req_o && wr_gnt_i;
    assign push     = run && rd_rvalid_i;
    assign last_cmp = run && wr_rvalid_i && ((wr_cmp_q + cnt_t'(1)) == len_q);

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_DONE);
    assign rd_addr_o = rd_addr_q;
    assign wr_addr_o = wr_addr_q;

    dma_fifo_buffer #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (rd_rdata_i),
        .pop_i   (wr_fire),
        .data_o  (wr_wdata_o),
        .count_o (fifo_cnt),
        .empty_o (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; DONE is a single-cycle pulse state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_i) state_d = (len_i == '0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_cmp) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Transfer parameters, address walkers and progress counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            len_q     <= '0;
            rd_iss_q  <= '0;
            rd_out_q  <= '0;
            wr_cmp_q  <= '0;
        end else if (launch) begin
            rd_addr_q <= src_addr_i;
            wr_addr_q <= dst_addr_i;
            len_q     <= {1'b0, len_i};
            rd_iss_q  <= '0;
            rd_out_q  <= '0;
            wr_cmp_q  <= '0;
        end else if (run) begin
            if (rd_fire) begin
                rd_addr_q <= rd_addr_q + 32'(WORD_BYTES);
                rd_iss_q  <= rd_iss_q + cnt_t'(1);
            end
            rd_out_q <= rd_out_q + cnt_t'(rd_fire) - cnt_t'(push);
            if (wr_fire)     wr_addr_q <= wr_addr_q + 32'(WORD_BYTES);
            if (wr_rvalid_i) wr_cmp_q  <= wr_cmp_q + cnt_t'(1);
        end
    end

endmodule

// File: doc/dma_xfer_ctrl.md
DMA_XFER_CTRL -- requirements
Module: dma_xfer_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, staging FIFO depth in words; SHALL be a power of 2 and at least 4.
REQ-002 Parameter LEN_W, default 16, width of the transfer-length field in words.
REQ-003 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  single-cycle start strobe; sampled only in IDLE.
REQ-006 src_addr_i  input  32  source byte address, word-aligned, captured at start.
REQ-007 dst_addr_i  input  32  destination byte address, word-aligned, captured at start.
REQ-008 len_i  input  LEN_W  transfer length in 32-bit words, captured at start.
REQ-009 busy_o  output  1  high while state is not IDLE.
REQ-010 done_o  output  1  one-cycle completion pulse.
REQ-011 rd_req_o / rd_addr_o[31:0] / rd_gnt_i / rd_rvalid_i / rd_rdata_i[31:0]  read master port, req/gnt/rvalid protocol.
REQ-012 wr_req_o / wr_addr_o[31:0] / wr_wdata_o[31:0] / wr_gnt_i / wr_rvalid_i  write master port, req/gnt/rvalid protocol (write data travels with the request).

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start_i with len_i != 0 SHALL capture the source address, destination address and length, and go to RUN.
REQ-015 In IDLE, start_i with len_i == 0 SHALL go to DONE without issuing any bus request.
REQ-016 start_i SHALL be ignored in RUN and in DONE.
REQ-017 DONE SHALL last exactly one cycle, assert done_o in that cycle, then return to IDLE.
REQ-018 Read issue: in RUN, rd_req_o SHALL be high while reads issued < len and (reads outstanding + FIFO count) < FIFO_DEPTH.
- FIFO overflow SHALL therefore be impossible.
REQ-019 rd_addr_o SHALL equal src + 4*(reads issued).
- It SHALL increment by 4 on every cycle with rd_req_o && rd_gnt_i.
- Once rd_req_o is asserted, rd_req_o and rd_addr_o SHALL hold stable until granted.
REQ-020 Each rd_rvalid_i SHALL push rd_rdata_i into the FIFO in the same cycle and decrement reads outstanding.
- rd_rvalid_i may arrive in the same cycle as a new grant; the outstanding counter SHALL net both events.
REQ-021 Write issue: in RUN, wr_req_o SHALL be high whenever the FIFO is non-empty.
- wr_wdata_o SHALL be the FIFO head.
- wr_addr_o SHALL be dst + 4*(writes granted).
REQ-022 On wr_req_o && wr_gnt_i, the FIFO SHALL pop and the write address SHALL increment by 4.
REQ-023 Push and pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-024 Each wr_rvalid_i SHALL increment the completed-writes counter.
- RUN SHALL move to DONE in the cycle after completed writes reach len.
REQ-025 Counters SHALL be LEN_W+1 bits wide; address arithmetic SHALL wrap modulo 2^32 with no error flag.
REQ-026 Minimum latency from start_i to the first rd_req_o SHALL be 1 cycle.
REQ-027 Minimum latency from the first rd_rvalid_i to the first wr_req_o SHALL be 1 cycle (FIFO registered).
REQ-028 Back-to-back throughput SHALL be 1 word/cycle when both ports grant every cycle and responses return 1 cycle after grant.

Reset
REQ-029 While rst_ni is low: state SHALL be IDLE, all counters, addresses and FIFO pointers SHALL be 0, and busy_o, done_o, rd_req_o and wr_req_o SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL abort immediately.
- Bus responses arriving after reset release SHALL be ignored while in IDLE.
- No done_o SHALL be produced for the aborted transfer.

Structure
REQ-031 A shared package dma_pkg SHALL hold the FSM state enum, the word-size constant (4) and the default parameter values.
REQ-032 The staging FIFO SHALL be one sub-module instance of dma_fifo_buffer (DEPTH=FIFO_DEPTH, DATA_WIDTH=32); all other logic SHALL reside in dma_xfer_ctrl.

Verification
REQ-033 src=0x1000, dst=0x2000, len=4, zero-wait grants, 1-cycle rvalid -> reads at 0x1000..0x100C, writes at 0x2000..0x200C with matching data, done_o pulses once, busy_o falls in the same cycle as done_o's cycle + 1.
REQ-034 len=0 start -> done_o one cycle after start_i; rd_req_o and wr_req_o never assert.
REQ-035 len=40, wr_gnt_i held low for 30 cycles -> FIFO reaches FIFO_DEPTH, rd_req_o deasserts, no data lost; all 40 words are written in order after the stall.
REQ-036 Random rd_gnt_i/wr_gnt_i backpressure with rvalid delay 1-5 cycles, len=100 -> destination image equals source; request and address stay stable while ungranted.
REQ-037 rst_ni pulsed low mid-transfer at word 7 of 20 -> all outputs 0, no done_o; a new start with len=3 then completes correctly.
REQ-038 start_i re-asserted during RUN -> ignored; captured parameters are unchanged.
